// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped 2-bit counters plus tagged BTB,
// trained from the resolved branch in execute; also produces mispredict/recovery info.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            BranchE,
  input  logic            TakebranchE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RecoverPCE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = XLEN - INDEX_BITS - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;

  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TAG_W-1:0]      w_tag_f;
  logic [INDEX_BITS-1:0] w_idx_e;
  logic [TAG_W-1:0]      w_tag_e;
  logic                  w_hit_e;
  logic                  w_mispredict;

  assign w_idx_f = PCF[INDEX_BITS+1:2];
  assign w_tag_f = PCF[XLEN-1:INDEX_BITS+2];
  assign w_idx_e = PCE[INDEX_BITS+1:2];
  assign w_tag_e = PCE[XLEN-1:INDEX_BITS+2];
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  // Read is combinational and sees only committed state, so a same-cycle update is not bypassed.
  assign PredTakenF  = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f) && r_ctr[w_idx_f][1];
  assign PredTargetF = PredTakenF ? r_target[w_idx_f] : '0;

  assign w_mispredict = BranchE && ((TakebranchE != PredTakenE) ||
                        (TakebranchE && PredTakenE && (PredTargetE != PCTargetE)));
  assign MispredictE  = w_mispredict;
  assign RecoverPCE   = TakebranchE ? PCTargetE : PCE + XLEN'(4);

  assign BranchCount     = r_branch_count;
  assign MispredictCount = r_mispredict_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (BranchE) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
      if (w_hit_e) begin
        if (TakebranchE) begin
          r_target[w_idx_e] <= PCTargetE;
          if (r_ctr[w_idx_e] != CTR_ST) begin
            r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'd1;
          end
        end else if (r_ctr[w_idx_e] != CTR_SNT) begin
          r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'd1;
        end
      end else if (TakebranchE) begin
        // Miss on a taken branch replaces whatever aliased entry lives at this index.
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= PCTargetE;
        r_ctr[w_idx_e]    <= CTR_WT;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor for the 5-stage RV32I pipeline: a direct-mapped table of 2-bit saturating counters combined with a tagged branch target buffer. Fetch reads a prediction for the current PC in the same cycle. The execute stage feeds back the resolved outcome from the branching unit, which is the other end of the prediction loop. The block trains its tables on that outcome and produces the misprediction/recovery signals used by the hazard unit to flush and redirect.

## Interface
- INDEX_BITS, 6, table index width; entries = 2**INDEX_BITS
- XLEN, 32, PC/target width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- PCF  in  XLEN  fetch-stage PC
- PredTakenF  out  1  fetch prediction: taken
- PredTargetF  out  XLEN  predicted target; valid only when PredTakenF=1, else 0
- BranchE  in  1  execute stage holds a valid conditional branch (not flushed)
- TakebranchE  in  1  resolved outcome from branching unit
- PCE  in  XLEN  PC of the branch in execute
- PCTargetE  in  XLEN  computed branch target in execute
- PredTakenE  in  1  PredTakenF pipelined to execute
- PredTargetE  in  XLEN  PredTargetF pipelined to execute
- MispredictE  out  1  combinational: redirect fetch, flush D/E
- RecoverPCE  out  XLEN  combinational: correct next PC on mispredict
- BranchCount  out  32  resolved branches since reset
- MispredictCount  out  32  mispredicts since reset

## Operation
- Index = PC[INDEX_BITS+1:2]; tag = PC[XLEN-1:INDEX_BITS+2].
- Per entry: valid (1), tag, target (XLEN), counter (2). Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Prediction (combinational on PCF): PredTakenF = valid & tag match & counter[1]. PredTargetF = stored target when PredTakenF=1, else 0.
- MispredictE = BranchE & ((TakebranchE != PredTakenE) | (TakebranchE & PredTakenE & PredTargetE != PCTargetE)).
- RecoverPCE = TakebranchE ? PCTargetE : PCE+4. Value is don't-care when MispredictE=0.
- Update on rising edge when BranchE=1, using the index and tag of PCE:
  - Tag hit (valid & tag match):
    - Counter increments on taken, saturating at 11.
    - Counter decrements on not-taken, saturating at 00.
    - On taken, target is overwritten with PCTargetE.
  - Tag miss, taken: allocate/replace the entry. valid=1, tag, target=PCTargetE, counter=10 (WT).
  - Tag miss, not-taken: no table change.
- BranchCount increments on every BranchE cycle. MispredictCount increments when MispredictE=1. Both wrap modulo 2^32.
- BranchE=0: no state changes.

## Timing
- Prediction path: zero latency, combinational from PCF.
- Training: the update is visible to PCF reads starting the cycle after the BranchE edge.
- Same-index read/write in one cycle: PCF sees the pre-update entry. There is no bypass.
- MispredictE and RecoverPCE: same cycle as BranchE, combinational.
- Reset:
  - All valid=0, all counters=01, all targets/tags=0.
  - Both perf counters=0.
  - PredTakenF=0 and PredTargetF=0 the cycle after reset.
  - A reset asserted concurrently with BranchE wins; no training occurs.
- Reset mid-run fully discards learned state. Counter-state encoding is retained only as reset values.
- Aliasing: two branches sharing an index but with different tags evict each other on taken outcomes only.

## Test plan
- Reset, PCF=0x40 -> PredTakenF=0, PredTargetF=0, counters 0/0.
- BranchE with PCE=0x40, taken, PCTargetE=0x80, PredTakenE=0 -> MispredictE=1, RecoverPCE=0x80. Next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x80.
- Same branch resolved not-taken twice after allocation -> counter 10→01→00. PCF=0x40 gives PredTakenF=0; RecoverPCE=0x44 on the first mispredict.
- Four consecutive taken on a hit entry -> counter saturates at 11. One not-taken -> 10, prediction still taken.
- Alias: PCE=0x40 taken, then PCE=0x140 taken (INDEX_BITS=6, same index) -> PCF=0x40 predicts not-taken; PCF=0x140 predicts 0x140's target.
- Read/write collision, plus reset concurrent with BranchE:
  - BranchE on 0x40 with PCF=0x40 the same cycle -> PredTakenF reflects the old entry.
  - Reset together with BranchE -> tables cleared, BranchCount=0.
